// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM peripheral: decoder states, command-byte
// layout and register-file address map.
package pwm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_DATA,
    ST_WR_STROBE,
    ST_RD_REQ,
    ST_RD_CAP,
    ST_RD_DUMMY
  } dcd_state_t;

  localparam int ADDR_W       = 6;
  localparam int CMD_RW_BIT   = 7;
  localparam int CMD_HI_BIT   = 6;
  localparam int CMD_ADDR_MSB = 5;
  localparam int CMD_ADDR_LSB = 0;

  localparam logic [ADDR_W-1:0] REG_PERIOD        = 6'h00;
  localparam logic [ADDR_W-1:0] REG_EN            = 6'h02;
  localparam logic [ADDR_W-1:0] REG_COMPARE1      = 6'h03;
  localparam logic [ADDR_W-1:0] REG_COMPARE2      = 6'h05;
  localparam logic [ADDR_W-1:0] REG_COUNTER_RESET = 6'h07;
  localparam logic [ADDR_W-1:0] REG_COUNTER_VAL   = 6'h08;
  localparam logic [ADDR_W-1:0] REG_PRESCALE      = 6'h0A;
  localparam logic [ADDR_W-1:0] REG_UPNOTDOWN     = 6'h0B;
  localparam logic [ADDR_W-1:0] REG_PWM_EN        = 6'h0C;
  localparam logic [ADDR_W-1:0] REG_FUNCTIONS     = 6'h0D;

  // Base address plus the high-byte select; wraps at 64 by width.
  function automatic logic [ADDR_W-1:0] cmd_eff_addr(input logic [7:0] cmd);
    return cmd[CMD_ADDR_MSB:CMD_ADDR_LSB] + {{(ADDR_W-1){1'b0}}, cmd[CMD_HI_BIT]};
  endfunction

endpackage

// File: rtl/instr_dcd_if.sv
// Bridge-side byte stream and register-file bus of the instruction decoder.
// master = decoder view, slave = bridge/register-file view.
interface instr_dcd_if;
  import pwm_pkg::*;

  logic              byte_sync;
  logic [7:0]        data_in;
  logic [7:0]        data_out;
  logic              read;
  logic              write;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        data_read;
  logic [7:0]        data_write;
  logic              busy;

  modport master (
    input  byte_sync, data_in, data_read,
    output data_out, read, write, addr, data_write, busy
  );

  modport slave (
    output byte_sync, data_in, data_read,
    input  data_out, read, write, addr, data_write, busy
  );
endinterface

// File: rtl/instr_dcd.sv
// Two-byte instruction decoder (command byte + data byte) between the SPI byte
// bridge and the PWM register file. Optional frame timeout: INSTR_DCD_TIMEOUT_EN.
module instr_dcd
  import pwm_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input logic       clk,
  input logic       rst_n,
  instr_dcd_if.master bus
);

  dcd_state_t        state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [7:0]        data_write_reg, data_write_next;
  logic [7:0]        data_out_reg, data_out_next;
  logic              pending_reg, pending_next;
  logic              timeout_hit;

`ifdef INSTR_DCD_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] cnt_reg, cnt_next;

  assign timeout_hit = (cnt_reg == TIMEOUT_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      addr_reg       <= '0;
      data_write_reg <= '0;
      data_out_reg   <= '0;
      pending_reg    <= 1'b0;
`ifdef INSTR_DCD_TIMEOUT_EN
      cnt_reg        <= '0;
`endif
    end else begin
      state_reg      <= state_next;
      addr_reg       <= addr_next;
      data_write_reg <= data_write_next;
      data_out_reg   <= data_out_next;
      pending_reg    <= pending_next;
`ifdef INSTR_DCD_TIMEOUT_EN
      cnt_reg        <= cnt_next;
`endif
    end
  end

  always_comb begin
    state_next      = state_reg;
    addr_next       = addr_reg;
    data_write_next = data_write_reg;
    data_out_next   = data_out_reg;
    pending_next    = pending_reg;

    unique case (state_reg)
      ST_IDLE: begin
        if (bus.byte_sync) begin
          addr_next  = cmd_eff_addr(bus.data_in);
          state_next = bus.data_in[CMD_RW_BIT] ? ST_WR_DATA : ST_RD_REQ;
        end
      end
      ST_WR_DATA: begin
        if (bus.byte_sync) begin
          data_write_next = bus.data_in;
          state_next      = ST_WR_STROBE;
        end else if (timeout_hit) begin
          state_next = ST_IDLE;
        end
      end
      ST_WR_STROBE: begin
        state_next = ST_IDLE;
      end
      // An early dummy byte during the read turnaround is remembered so the
      // bridge is not left waiting on a byte it already sent.
      ST_RD_REQ: begin
        if (bus.byte_sync) pending_next = 1'b1;
        state_next = ST_RD_CAP;
      end
      ST_RD_CAP: begin
        data_out_next = bus.data_read;
        if (bus.byte_sync) pending_next = 1'b1;
        state_next = ST_RD_DUMMY;
      end
      ST_RD_DUMMY: begin
        if (pending_reg || bus.byte_sync) begin
          pending_next = 1'b0;
          state_next   = ST_IDLE;
        end else if (timeout_hit) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next   = ST_IDLE;
        pending_next = 1'b0;
      end
    endcase
  end

`ifdef INSTR_DCD_TIMEOUT_EN
  // Counts only while parked in a byte-wait state; any transition clears it.
  always_comb begin
    cnt_next = '0;
    if ((state_next == state_reg) &&
        ((state_reg == ST_WR_DATA) || (state_reg == ST_RD_DUMMY)))
      cnt_next = cnt_reg + 16'd1;
  end
`endif

  assign bus.read       = (state_reg == ST_RD_REQ);
  assign bus.write      = (state_reg == ST_WR_STROBE);
  assign bus.busy       = (state_reg != ST_IDLE);
  assign bus.addr       = addr_reg;
  assign bus.data_write = data_write_reg;
  assign bus.data_out   = data_out_reg;

endmodule

// File: tb/tb_instr_dcd.sv
// Directed testbench for instr_dcd with a small register-file model.
// Build with +define+INSTR_DCD_TIMEOUT_EN to exercise the frame timeout.
module tb_instr_dcd;

  logic clk = 1'b0;
  logic rst_n;

  instr_dcd_if dut_if ();

  instr_dcd #(.TIMEOUT_CYCLES(16)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dut_if.master)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  int overlap_cnt = 0;

  logic [7:0] regs [64];
  bit loaded = 1'b0;

  // Register-file model: write on strobe, read data valid the cycle after read.
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 64; i++) regs[i] <= 8'h00;
      regs[6'h0A] <= 8'h07;
      regs[6'h0B] <= 8'h5A;
      regs[6'h0D] <= 8'h3C;
      loaded <= 1'b1;
    end else begin
      if (dut_if.write) regs[dut_if.addr] <= dut_if.data_write;
      if (dut_if.read) dut_if.data_read <= regs[dut_if.addr];
    end
  end

  always @(posedge clk) begin
    if (rst_n === 1'b1) begin
      if (dut_if.write) wr_cnt++;
      if (dut_if.read) rd_cnt++;
      if (dut_if.write && dut_if.read) overlap_cnt++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    dut_if.byte_sync = 1'b1;
    dut_if.data_in   = b;
    @(negedge clk);
    dut_if.byte_sync = 1'b0;
    $display("[TB] byte 0x%02h sent", b);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  int wr0, rd0;

  initial begin
    rst_n = 1'b0;
    dut_if.byte_sync = 1'b0;
    dut_if.data_in   = 8'h00;
    dut_if.data_read = 8'h00;
    repeat (2) @(negedge clk);
    check_eq("rst_busy", dut_if.busy, 0);
    check_eq("rst_read", dut_if.read, 0);
    check_eq("rst_write", dut_if.write, 0);
    check_eq("rst_addr", dut_if.addr, 0);
    check_eq("rst_dwrite", dut_if.data_write, 0);
    check_eq("rst_dout", dut_if.data_out, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Write LSB of PERIOD
    wr0 = wr_cnt; rd0 = rd_cnt;
    send_byte(8'h80);
    check_eq("wl_busy", dut_if.busy, 1);
    send_byte(8'h34);
    check_eq("wl_write", dut_if.write, 1);
    check_eq("wl_addr", dut_if.addr, 8'h00);
    check_eq("wl_dwrite", dut_if.data_write, 8'h34);
    check_eq("wl_read", dut_if.read, 0);
    @(negedge clk);
    check_eq("wl_idle", dut_if.busy, 0);
    check_eq("wl_wend", dut_if.write, 0);
    check_eq("wl_wcnt", wr_cnt - wr0, 1);
    check_eq("wl_rcnt", rd_cnt - rd0, 0);
    $display("[TB] write 0x34 -> addr 0x00");

    // Write MSB of PERIOD
    send_byte(8'hC0);
    send_byte(8'h12);
    check_eq("wm_write", dut_if.write, 1);
    check_eq("wm_addr", dut_if.addr, 8'h01);
    check_eq("wm_dwrite", dut_if.data_write, 8'h12);
    @(negedge clk);
    check_eq("wm_period", {regs[1], regs[0]}, 16'h1234);
    $display("[TB] write 0x12 -> addr 0x01");

    // Read PRESCALE
    rd0 = rd_cnt;
    send_byte(8'h0A);
    check_eq("rd_read", dut_if.read, 1);
    check_eq("rd_addr", dut_if.addr, 8'h0A);
    check_eq("rd_write", dut_if.write, 0);
    @(negedge clk);
    check_eq("rd_dout_early", dut_if.data_out, 8'h00);
    @(negedge clk);
    check_eq("rd_dout", dut_if.data_out, 8'h07);
    check_eq("rd_busy", dut_if.busy, 1);
    send_byte(8'hFF);
    check_eq("rd_idle", dut_if.busy, 0);
    check_eq("rd_rcnt", rd_cnt - rd0, 1);
    $display("[TB] read addr 0x0A -> 0x%02h", dut_if.data_out);

    // Read PERIOD MSB back through the decoder
    send_byte(8'h40);
    check_eq("rh_addr", dut_if.addr, 8'h01);
    repeat (2) @(negedge clk);
    check_eq("rh_dout", dut_if.data_out, 8'h12);
    send_byte(8'h00);
    check_eq("rh_idle", dut_if.busy, 0);
    $display("[TB] read addr 0x01 -> 0x%02h", dut_if.data_out);

    // Fast dummy byte lands in RD_CAP
    rd0 = rd_cnt;
    send_byte(8'h0B);
    check_eq("fd_read", dut_if.read, 1);
    send_byte(8'hFF);
    check_eq("fd_dout", dut_if.data_out, 8'h5A);
    check_eq("fd_busy", dut_if.busy, 1);
    check_eq("fd_noread", dut_if.read, 0);
    @(negedge clk);
    check_eq("fd_idle", dut_if.busy, 0);
    check_eq("fd_rcnt", rd_cnt - rd0, 1);
    $display("[TB] fast-dummy read addr 0x0B -> 0x%02h", dut_if.data_out);

    // Address wrap: base 63 + high select
    send_byte(8'hFF);
    send_byte(8'hAB);
    check_eq("wrap_addr", dut_if.addr, 8'h00);
    check_eq("wrap_dwrite", dut_if.data_write, 8'hAB);
    check_eq("wrap_write", dut_if.write, 1);
    $display("[TB] write 0xAB -> addr 0x00 (wrap)");

    // Back-to-back: command accepted in first IDLE cycle after a write
    send_byte(8'h8C);
    send_byte(8'h03);
    check_eq("b2b_write", dut_if.write, 1);
    check_eq("b2b_waddr", dut_if.addr, 8'h0C);
    send_byte(8'h0D);
    check_eq("b2b_read", dut_if.read, 1);
    check_eq("b2b_raddr", dut_if.addr, 8'h0D);
    repeat (2) @(negedge clk);
    check_eq("b2b_dout", dut_if.data_out, 8'h3C);
    send_byte(8'h00);
    check_eq("b2b_idle", dut_if.busy, 0);
    $display("[TB] back-to-back write 0x0C / read 0x0D");

    // Reset mid-frame
    wr0 = wr_cnt;
    send_byte(8'h80);
    check_eq("rm_busy", dut_if.busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rm_busy0", dut_if.busy, 0);
    check_eq("rm_dout0", dut_if.data_out, 0);
    check_eq("rm_dwrite0", dut_if.data_write, 0);
    check_eq("rm_addr0", dut_if.addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_byte(8'h82);
    send_byte(8'h01);
    check_eq("rm_write", dut_if.write, 1);
    check_eq("rm_addr", dut_if.addr, 8'h02);
    check_eq("rm_dwrite", dut_if.data_write, 8'h01);
    @(negedge clk);
    check_eq("rm_wcnt", wr_cnt - wr0, 1);
    $display("[TB] reset mid-frame, then write 0x01 -> addr 0x02");

`ifdef INSTR_DCD_TIMEOUT_EN
    wr0 = wr_cnt;
    send_byte(8'h83);
    repeat (15) @(negedge clk);
    check_eq("to_busy", dut_if.busy, 1);
    @(negedge clk);
    check_eq("to_idle", dut_if.busy, 0);
    send_byte(8'h0D);
    check_eq("to_read", dut_if.read, 1);
    check_eq("to_addr", dut_if.addr, 8'h0D);
    repeat (2) @(negedge clk);
    send_byte(8'h00);
    check_eq("to_done", dut_if.busy, 0);
    check_eq("to_wcnt", wr_cnt - wr0, 0);
    $display("[TB] timeout after 0x83, then read 0x0D");
`else
    send_byte(8'h83);
    repeat (40) @(negedge clk);
    check_eq("wait_busy", dut_if.busy, 1);
    send_byte(8'h77);
    check_eq("wait_write", dut_if.write, 1);
    check_eq("wait_addr", dut_if.addr, 8'h03);
    check_eq("wait_dwrite", dut_if.data_write, 8'h77);
    @(negedge clk);
    check_eq("wait_idle", dut_if.busy, 0);
    $display("[TB] late data byte 0x77 -> addr 0x03");
`endif

    check_eq("rw_overlap", overlap_cnt, 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/instr_dcd.md
# instr_dcd

Instruction decoder between the SPI byte bridge and the PWM register file. It receives framed bytes from the bridge and decodes a two-byte instruction: a command byte followed by a data byte. Writes become single-cycle `write` strobes toward the register file. Reads are issued to the register file right after the command byte, and the returned byte is staged on `data_out` so the bridge can shift it out during the second byte.

## Interface
- `TIMEOUT_CYCLES`, default 4096: cycles allowed between command byte and data byte before the frame is abandoned (only with `INSTR_DCD_TIMEOUT_EN`).
- `clk` in 1: peripheral clock.
- `rst_n` in 1: reset, asynchronous, active-low. One clock; all state resets asynchronously on `rst_n` low.
- `byte_sync` in 1: one-cycle pulse; `data_in` is valid in that cycle.
- `data_in` in 8: byte received from the bridge.
- `data_out` out 8: byte to transmit on the next bridge byte.
- `read` out 1: one-cycle read strobe to the register file.
- `write` out 1: one-cycle write strobe to the register file.
- `addr` out 6: register address.
- `data_read` in 8: register file read data, valid the cycle after `read`.
- `data_write` out 8: register file write data.
- `busy` out 1: high while a frame is in progress (state ≠ IDLE).

## Operation
- Command byte fields:
  - bit7 = 1 write, 0 read.
  - bit6 = high-byte select.
  - bits5:0 = base address.
- Effective address: `addr` = base + bit6, modulo 64. 16-bit registers occupy base (LSB, bits 7:0) and base+1 (MSB, bits 15:8).
- States: IDLE, WR_DATA, WR_STROBE, RD_REQ, RD_CAP, RD_DUMMY.
- IDLE:
  - On `byte_sync`, latch `addr`.
  - bit7=1 → WR_DATA.
  - bit7=0 → RD_REQ.
- WR_DATA: on `byte_sync`, latch `data_write` ← `data_in` → WR_STROBE.
- WR_STROBE: `write`=1 for exactly this cycle → IDLE.
- RD_REQ: `read`=1 for exactly this cycle → RD_CAP.
- RD_CAP: `data_out` ← `data_read` → RD_DUMMY.
- RD_DUMMY: on `byte_sync` (dummy byte, content ignored) → IDLE.
- A `byte_sync` arriving in RD_REQ or RD_CAP sets a pending flag. RD_DUMMY consumes the flag as the dummy byte and goes to IDLE in its first cycle.
- `read` and `write` are never high together. Neither is high outside RD_REQ / WR_STROBE.
- `addr`, `data_write` and `data_out` hold their values until next overwritten. `data_out` changes only in RD_CAP.
- Reset values: `read`=0, `write`=0, `addr`=0, `data_write`=0, `data_out`=0, `busy`=0, state IDLE, pending=0.
- Reset mid-frame: immediate return to IDLE with reset values. A partial frame is discarded and issues no strobe.

## Timing
- Cycle numbering: a `byte_sync` sampled in cycle N.
- Write: data byte at N → `write`=1 in N+1 with stable `addr`/`data_write` → `busy`=0 in N+2.
- Read: command byte at N → `read`=1 in N+1 → register file responds in N+2 → `data_out` valid from N+3.
- The bridge must not request the reply byte before N+3. A bridge at ≥8 clk per byte meets this.
- Back-to-back frames: a command `byte_sync` is accepted in the first IDLE cycle after the previous frame.

## Configuration
- `INSTR_DCD_TIMEOUT_EN` defined:
  - A 16-bit cycle counter runs in WR_DATA and RD_DUMMY and is cleared on entry.
  - When it reaches `TIMEOUT_CYCLES` without a `byte_sync`, the state returns to IDLE.
  - No strobe is issued; `data_out` is unchanged.
  - `TIMEOUT_CYCLES` is restricted to 1..65535.
- Not defined: no counter; WR_DATA and RD_DUMMY wait indefinitely. `TIMEOUT_CYCLES` is ignored.

## Structure
- Shared package `pwm_pkg`:
  - State enum type.
  - Command bit positions (RW=7, HI=6, ADDR=5:0).
  - Register address constants: PERIOD 0x00, EN 0x02, COMPARE1 0x03, COMPARE2 0x05, COUNTER_RESET 0x07, COUNTER_VAL 0x08, PRESCALE 0x0A, UPNOTDOWN 0x0B, PWM_EN 0x0C, FUNCTIONS 0x0D.
- No sub-module; the timeout counter is inline in the FSM.

## Test plan
- Write LSB: bytes 0x80, 0x34 → one `write` pulse, `addr`=0x00, `data_write`=0x34; `read` stays 0.
- Write MSB: bytes 0xC0, 0x12 → `addr`=0x01, `data_write`=0x12; register file period reads back 0x1234.
- Read: bytes 0x0A, dummy 0xFF with prescale=0x07 → one `read` pulse with `addr`=0x0A in N+1; `data_out`=0x07 from N+3.
- Fast dummy: dummy `byte_sync` in N+2 (RD_CAP) → pending flag set; `data_out` still captured; IDLE one cycle after RD_DUMMY entry; no second `read`.
- Reset mid-frame: 0x80, then `rst_n` low before the data byte → no `write`, all outputs 0; next frame 0x82, 0x01 writes `addr`=0x02.
- Timeout (macro on, `TIMEOUT_CYCLES`=16): byte 0x83 only → after 16 cycles `busy`=0; next byte 0x0D is decoded as a read command.
